// File: rtl/serial_pkg.sv
// Shared serial line definitions: default timing/width and FSM state encodings.
// Common to serial_tx and the matching receiver.
package serial_pkg;

    localparam int unsigned CLKS_PER_BIT_DEF = 4;
    localparam int unsigned DATA_W_DEF       = 8;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } state_e;

endpackage

// File: rtl/serial_tx_if.sv
// Valid/ready payload handshake between a producer (master) and serial_tx (slave).
interface serial_tx_if #(
    parameter int unsigned DATA_W = serial_pkg::DATA_W_DEF
);

    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/bit_timer.sv
// Bit-period down-counter: reload on load, expire flags the final cycle of the period.
module bit_timer
    import serial_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic expire
);

    localparam int unsigned      CNT_W  = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= RELOAD;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign expire = (r_cnt == '0);

endmodule

// File: rtl/serial_tx.sv
// UART-style serial transmitter: start bit, DATA_W bits LSB first, optional even parity
// (define SERIAL_TX_PARITY_EN), stop bit. tx_out is registered and idles high.
module serial_tx
    import serial_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned DATA_W       = DATA_W_DEF
) (
    input  logic        clk,
    input  logic        reset,
    serial_tx_if.slave  tx_if,
    output logic        tx_out,
    output logic        busy
);

    localparam int unsigned      IDX_W    = $clog2(DATA_W + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    state_e            r_state, w_state_d;
    logic [DATA_W-1:0] r_shift, w_shift_d;
    logic [IDX_W-1:0]  r_bit_idx, w_bit_idx_d;
    logic              r_tx_out, w_tx_out_d;
    logic              w_load;
    logic              w_expire;
    logic              w_handshake;
`ifdef SERIAL_TX_PARITY_EN
    logic              r_parity;
`endif

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (w_load),
        .expire (w_expire)
    );

    assign tx_if.tx_ready = (r_state == StIdle);
    assign busy           = (r_state != StIdle);
    assign tx_out         = r_tx_out;
    assign w_handshake    = tx_if.tx_valid && (r_state == StIdle);

    always_comb begin
        w_state_d   = r_state;
        w_shift_d   = r_shift;
        w_bit_idx_d = r_bit_idx;
        w_tx_out_d  = r_tx_out;
        w_load      = 1'b0;
        case (r_state)
            StIdle: begin
                w_tx_out_d = 1'b1;
                if (w_handshake) begin
                    w_state_d   = StStart;
                    w_shift_d   = tx_if.tx_data;
                    w_bit_idx_d = '0;
                    w_tx_out_d  = 1'b0;
                    w_load      = 1'b1;
                end
            end
            StStart: begin
                if (w_expire) begin
                    w_state_d  = StData;
                    w_tx_out_d = r_shift[0];
                    w_load     = 1'b1;
                end
            end
            StData: begin
                if (w_expire) begin
                    w_load = 1'b1;
                    if (r_bit_idx == LAST_IDX) begin
`ifdef SERIAL_TX_PARITY_EN
                        w_state_d  = StParity;
                        w_tx_out_d = r_parity;
`else
                        w_state_d  = StStop;
                        w_tx_out_d = 1'b1;
`endif
                    end else begin
                        // Shift so the next bit to send is always at index 1 of the current word.
                        w_bit_idx_d = r_bit_idx + IDX_W'(1);
                        w_shift_d   = r_shift >> 1;
                        w_tx_out_d  = r_shift[1];
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            StParity: begin
                if (w_expire) begin
                    w_state_d  = StStop;
                    w_tx_out_d = 1'b1;
                    w_load     = 1'b1;
                end
            end
`endif
            StStop: begin
                if (w_expire) begin
                    w_state_d  = StIdle;
                    w_tx_out_d = 1'b1;
                end
            end
            default: begin
                w_state_d  = StIdle;
                w_tx_out_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= StIdle;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_tx_out  <= 1'b1;
        end else begin
            r_state   <= w_state_d;
            r_shift   <= w_shift_d;
            r_bit_idx <= w_bit_idx_d;
            r_tx_out  <= w_tx_out_d;
        end
    end

`ifdef SERIAL_TX_PARITY_EN
    // Parity is latched with the payload because the shift register is consumed during DATA.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_parity <= 1'b0;
        end else if (w_handshake) begin
            r_parity <= ^tx_if.tx_data;
        end
    end
`endif

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: directed and random frames checked cycle by cycle
// against a frame-level line model (honours SERIAL_TX_PARITY_EN).
module tb_serial_tx;

    localparam int unsigned C = 4;
    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tx_out;
    logic busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic exp_line[$];
    logic exp_busy[$];

    serial_tx_if #(.DATA_W(W)) tx_if ();

    serial_tx #(
        .CLKS_PER_BIT(C),
        .DATA_W      (W)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .tx_if  (tx_if),
        .tx_out (tx_out),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Line model: each symbol of the frame is held for C cycles with busy high.
    task automatic push_frame(input logic [W-1:0] d);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < W; i++) bits.push_back(((d >> i) & 1) != 0);
`ifdef SERIAL_TX_PARITY_EN
        bits.push_back(($countones(d) % 2) == 1);
`endif
        bits.push_back(1'b1);
        foreach (bits[b]) begin
            for (int k = 0; k < C; k++) begin
                exp_line.push_back(bits[b]);
                exp_busy.push_back(1'b1);
            end
        end
    endtask

    task automatic push_idle(input int n);
        for (int k = 0; k < n; k++) begin
            exp_line.push_back(1'b1);
            exp_busy.push_back(1'b0);
        end
    endtask

    task automatic play(input string tag, input int max_cycles, input logic v_after,
                        input logic [W-1:0] d_after);
        logic el;
        logic eb;
        for (int i = 0; i < max_cycles && exp_line.size() > 0; i++) begin
            @(negedge clk);
            el = exp_line.pop_front();
            eb = exp_busy.pop_front();
            check({tag, " tx_out"}, 32'(tx_out), 32'(el));
            check({tag, " busy"}, 32'(busy), 32'(eb));
            check({tag, " tx_ready"}, 32'(tx_if.tx_ready), 32'(!eb));
            tx_if.tx_valid = (exp_line.size() > 0) ? v_after : 1'b0;
            tx_if.tx_data  = d_after;
        end
    endtask

    task automatic send(input string tag, input logic [W-1:0] d, input logic [W-1:0] d_after);
        tx_if.tx_valid = 1'b1;
        tx_if.tx_data  = d;
        push_frame(d);
        push_idle(1);
        play(tag, 1000, 1'b0, d_after);
    endtask

    initial begin
        logic [W-1:0] d;
        tx_if.tx_valid = 1'b0;
        tx_if.tx_data  = '0;
        reset          = 1'b0;
        repeat (2) @(negedge clk);
        check("reset tx_out", 32'(tx_out), 32'(1));
        check("reset busy", 32'(busy), 32'(0));
        check("reset tx_ready", 32'(tx_if.tx_ready), 32'(1));
        reset = 1'b1;

        send("a5", 8'hA5, 8'h5A);
        send("01", 8'h01, 8'hFE);
        send("00 then ff", 8'h00, 8'hFF);

        for (int i = 0; i < 6; i++) begin
            d = W'($urandom);
            send("random", d, W'($urandom));
        end

        // Back-to-back with valid held: exactly one idle-high cycle between frames.
        tx_if.tx_valid = 1'b1;
        tx_if.tx_data  = 8'h55;
        push_frame(8'h55);
        push_idle(1);
        push_frame(8'h0F);
        push_idle(1);
        play("b2b", 1000, 1'b1, 8'h0F);

        // Reset in the middle of data bit 3.
        d = W'($urandom);
        tx_if.tx_valid = 1'b1;
        tx_if.tx_data  = d;
        push_frame(d);
        play("pre-abort", 4 * C + 2, 1'b0, d);
        exp_line.delete();
        exp_busy.delete();
        reset = 1'b0;
        @(negedge clk);
        check("abort tx_out", 32'(tx_out), 32'(1));
        check("abort busy", 32'(busy), 32'(0));
        check("abort tx_ready", 32'(tx_if.tx_ready), 32'(1));
        reset = 1'b1;
        push_idle(2 * C);
        play("post-abort", 1000, 1'b0, d);

        // Valid during reset is ignored; first frame starts right after release.
        d = W'($urandom);
        reset          = 1'b0;
        tx_if.tx_valid = 1'b1;
        tx_if.tx_data  = d;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("in-reset tx_out", 32'(tx_out), 32'(1));
            check("in-reset busy", 32'(busy), 32'(0));
        end
        reset = 1'b1;
        push_frame(d);
        push_idle(1);
        play("after-release", 1000, 1'b0, W'($urandom));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4, clock cycles per serial bit; legal range 2..65535.
REQ-002 SHALL have parameter DATA_W, default 8, payload bits per frame; legal range 5..9.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
REQ-005 SHALL have port tx_data  input  DATA_W  payload to transmit, sampled only on an accepted handshake.
REQ-006 SHALL have port tx_valid  input  1  producer requests transmission of tx_data.
REQ-007 SHALL have port tx_ready  output  1  block can accept a payload this cycle.
REQ-008 SHALL have port tx_out  output  1  serial line, idle high.
REQ-009 SHALL have port busy  output  1  frame in progress (any state other than IDLE).

Function
REQ-010 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-011 SHALL assert tx_ready only in IDLE; handshake occurs on a cycle with tx_valid=1 and tx_ready=1.
REQ-012 SHALL, on handshake, register tx_data into an internal shift register and enter START on the next cycle.
REQ-013 SHALL ignore tx_valid and tx_data outside IDLE; changes after handshake do not alter the frame.
REQ-014 SHALL drive tx_out=1 in IDLE, 0 in START, then DATA_W data bits LSB first, then (if compiled in) a parity bit, then 1 in STOP.
REQ-015 SHALL hold every bit, including start and stop, for exactly CLKS_PER_BIT cycles, timed by a down-counter reloaded at each bit boundary.
REQ-016 SHALL track data bit index with a counter of width ceil(log2(DATA_W+1)); DATA->next state when the last bit's period expires.
REQ-017 SHALL return STOP->IDLE when the stop period expires; frame length is (DATA_W+2[+1 with parity])*CLKS_PER_BIT cycles.
REQ-018 SHALL spend at least one cycle in IDLE between frames; back-to-back frames with tx_valid held high are separated by exactly one idle-high cycle.
REQ-019 SHALL register tx_out (no combinational path from any input to tx_out).
REQ-020 SHALL derive busy from state only; busy=~tx_ready at all times.

Reset
REQ-021 SHALL, when reset=0 at a rising clk edge, enter IDLE, set tx_out=1, tx_ready=1, busy=0, clear bit counter, timer and shift register.
REQ-022 SHALL abort any frame in progress on reset; tx_out is 1 from the first edge with reset=0, with no further start or data bits.
REQ-023 SHALL ignore tx_valid during reset; a handshake can first occur on the edge after reset returns to 1.

Configuration
REQ-024 SHALL compile the PARITY state and parity bit only when macro SERIAL_TX_PARITY_EN is defined.
REQ-025 SHALL, with SERIAL_TX_PARITY_EN, send even parity (XOR of all DATA_W payload bits) for one bit period between DATA and STOP.
REQ-026 SHALL, without SERIAL_TX_PARITY_EN, go DATA->STOP directly; PARITY state encoding is never reached.

Structure
REQ-027 SHALL place state encodings, default CLKS_PER_BIT and DATA_W in shared package serial_pkg, reused by the matching receiver.
REQ-028 SHALL implement the bit-period down-counter as sub-module bit_timer (inputs clk, reset, load; output expire).

Verification
REQ-029 CLKS_PER_BIT=4, no parity, send 0xA5 -> tx_out 0 for 4 cycles, then 1,0,1,0,0,1,0,1 each 4 cycles, then 1 for 4; busy high 40 cycles.
REQ-030 Same with SERIAL_TX_PARITY_EN, send 0xA5 -> parity bit 0 after data; send 0x01 -> parity bit 1; frame 44 cycles.
REQ-031 tx_valid held high with 0x55 then 0x0F -> second start bit begins exactly one idle-high cycle after first stop bit ends.
REQ-032 tx_data changed to 0xFF one cycle after handshake of 0x00 -> transmitted data bits all 0.
REQ-033 reset=0 asserted during data bit 3 -> tx_out=1, tx_ready=1, busy=0 after that edge; no further 0 on line until new handshake.
REQ-034 tx_valid=1 while reset=0 -> no handshake; first start bit begins the cycle after the first handshake edge following reset release.
